// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types for the register-file writeback controller: widths, FSM states,
// round-robin source encoding and the writeback request payload.
package regfile_wb_ctrl_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    // Bit positions inside the arbiter grant vector
    localparam int unsigned GNT_CORE = 0;
    localparam int unsigned GNT_AUX  = 1;

    typedef enum logic {WB_INIT, WB_RUN} wb_state_e;
    typedef enum logic {RR_CORE, RR_AUX} wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-way round-robin grant: combinational from the valids and the priority
// pointer, which lives in the parent.
module wb_rr_arbiter2
    import regfile_wb_ctrl_pkg::*;
(
    input  logic       core_valid,
    input  logic       aux_valid,
    input  wb_src_e    rr_ptr,
    output logic [1:0] grant,
    output logic       contended
);

    always_comb begin
        contended = core_valid && aux_valid;
        grant     = '0;
        if (contended) begin
            if (rr_ptr == RR_AUX) grant[GNT_AUX]  = 1'b1;
            else                  grant[GNT_CORE] = 1'b1;
        end else begin
            grant[GNT_CORE] = core_valid;
            grant[GNT_AUX]  = aux_valid;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Owner of the register_file write port: optional post-reset init sweep
// (RF_WB_INIT_SWEEP_EN), then round-robin arbitration of core/aux writebacks.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned     NUM_REGS   = 32,
    parameter logic [XLEN-1:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_valid,
    output logic                      core_ready,
    input  logic [REG_ADDR_WIDTH-1:0] core_rd,
    input  logic [XLEN-1:0]           core_data,
    input  logic                      aux_valid,
    output logic                      aux_ready,
    input  logic [REG_ADDR_WIDTH-1:0] aux_rd,
    input  logic [XLEN-1:0]           aux_data,
    output logic                      init_done,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [XLEN-1:0]           rf_wdata
);

    wb_src_e                   rr_ptr_q, rr_ptr_d;
    logic                      init_done_q;
    logic [1:0]                grant;
    logic                      contended;
    logic                      accept;
    wb_req_t                   win_req;
    logic                      rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_d;
    logic [XLEN-1:0]           rf_wdata_d;

`ifdef RF_WB_INIT_SWEEP_EN
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_ADDR = REG_ADDR_WIDTH'(NUM_REGS - 1);
    wb_state_e                 state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

    wb_rr_arbiter2 u_arb (
        .core_valid (core_valid),
        .aux_valid  (aux_valid),
        .rr_ptr     (rr_ptr_q),
        .grant      (grant),
        .contended  (contended)
    );

    // Requesters are only served once init_done is registered high, so the
    // cycle carrying the last sweep write never overlaps an accept.
    assign core_ready = init_done_q && grant[GNT_CORE];
    assign aux_ready  = init_done_q && grant[GNT_AUX];
    assign accept     = core_ready || aux_ready;
    assign win_req    = grant[GNT_AUX] ? {aux_rd, aux_data} : {core_rd, core_data};
    assign init_done  = init_done_q;

    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_rd_addr;
        rf_wdata_d = rf_wdata;
        rr_ptr_d   = rr_ptr_q;
`ifdef RF_WB_INIT_SWEEP_EN
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (state_q == WB_INIT) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = cnt_q;
            rf_wdata_d = INIT_VALUE;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = WB_RUN;
        end else
`endif
        if (accept) begin
            // x0 requests complete the handshake but never write
            rf_we_d    = (win_req.rd != '0);
            rf_addr_d  = win_req.rd;
            rf_wdata_d = win_req.data;
            if (contended) rr_ptr_d = grant[GNT_CORE] ? RR_AUX : RR_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_rd_addr  <= '0;
            rf_wdata    <= '0;
            init_done_q <= 1'b0;
            rr_ptr_q    <= RR_CORE;
`ifdef RF_WB_INIT_SWEEP_EN
            state_q     <= WB_INIT;
            cnt_q       <= REG_ADDR_WIDTH'(1);
`endif
        end else begin
            rf_we       <= rf_we_d;
            rf_rd_addr  <= rf_addr_d;
            rf_wdata    <= rf_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef RF_WB_INIT_SWEEP_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_q == WB_RUN);
`else
            init_done_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized bench for regfile_wb_ctrl against a transaction-level model
// (request queues, sweep address list, architectural register array).
module tb_regfile_wb_ctrl;

    localparam logic [31:0] INIT_V = 32'h0000_0000;
    localparam logic [31:0] PRE_V  = 32'hDEAD_BEEF;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_valid = 1'b0, aux_valid = 1'b0;
    logic        core_ready, aux_ready;
    logic [4:0]  core_rd = '0, aux_rd = '0;
    logic [31:0] core_data = '0, aux_data = '0;
    logic        init_done, rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_ready(core_ready), .core_rd(core_rd), .core_data(core_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
        .init_done(init_done), .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // register_file stand-in written only by the DUT's port (plus preload)
    logic [31:0] tb_rf [32];
    bit          pre_en = 1'b1;
    bit          x0_hit;
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 1; i < 32; i++) tb_rf[i] <= PRE_V;
            x0_hit <= 1'b0;
        end else if (rf_we) begin
            if (rf_rd_addr == 5'd0) x0_hit <= 1'b1;
            else                    tb_rf[rf_rd_addr] <= rf_wdata;
        end
    end

    // reference model
    req_t        core_q[$], aux_q[$];
    int          sweep_q[$];
    bit          m_done, m_pref_aux;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rf [32];
    bit          e_cr, e_ar;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_addr = '0; m_data = '0;
        m_done = 1'b0; m_pref_aux = 1'b0;
        sweep_q.delete();
`ifdef RF_WB_INIT_SWEEP_EN
        for (int i = 1; i < 32; i++) sweep_q.push_back(i);
`endif
    endtask

    task automatic cycle(input bit r);
        req_t win;
        @(negedge clk);
        chk("outs", {25'd0, rf_we, init_done, rf_rd_addr, rf_wdata},
                    {25'd0, m_we, m_done, m_addr, m_data});
        rst        = r;
        core_valid = core_q.size() != 0;
        aux_valid  = aux_q.size() != 0;
        {core_rd, core_data} = core_valid ? {core_q[0].rd, core_q[0].data} : 37'd0;
        {aux_rd, aux_data}   = aux_valid  ? {aux_q[0].rd, aux_q[0].data}   : 37'd0;
        e_cr = m_done && core_valid && (!aux_valid || !m_pref_aux);
        e_ar = m_done && aux_valid && (!core_valid || m_pref_aux);
        #1;
        chk("ready", {62'd0, core_ready, aux_ready}, {62'd0, e_cr, e_ar});
        @(posedge clk);
        if (m_we && m_addr != 0) m_rf[m_addr] = m_data;
        win = '{rd: 5'd0, data: 32'd0};
        if (e_cr) win = core_q.pop_front();
        if (e_ar) win = aux_q.pop_front();
        if (r) begin
            model_reset();
        end else if (m_done) begin
            m_we = (e_cr || e_ar) && win.rd != 0;
            if (e_cr || e_ar) begin m_addr = win.rd; m_data = win.data; end
            if (core_valid && aux_valid) m_pref_aux = !m_pref_aux;
        end else if (sweep_q.size() != 0) begin
            m_we = 1'b1; m_addr = 5'(sweep_q.pop_front()); m_data = INIT_V;
        end else begin
            m_we = 1'b0; m_done = 1'b1;
        end
    endtask

    task automatic wait_init();
        for (int k = 0; k < 100 && !m_done; k++) cycle(1'b0);
        chk("init_reached", {63'd0, m_done}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (core_q.size() + aux_q.size()) != 0; k++) cycle(1'b0);
        repeat (2) cycle(1'b0);
        #1;
    endtask

    task automatic push_core(input logic [4:0] rd, input logic [31:0] d);
        req_t q; q.rd = rd; q.data = d; core_q.push_back(q);
    endtask

    task automatic push_aux(input logic [4:0] rd, input logic [31:0] d);
        req_t q; q.rd = rd; q.data = d; aux_q.push_back(q);
    endtask

    initial begin
        logic [3:0]  seq;
        logic [31:0] exp_sw;
        model_reset();
        m_rf[0] = '0;
        for (int i = 1; i < 32; i++) m_rf[i] = PRE_V;
        @(posedge clk); #1 pre_en = 1'b0;
        @(posedge clk);
        cycle(1'b1);
        wait_init();
        #1;
`ifdef RF_WB_INIT_SWEEP_EN
        exp_sw = INIT_V;
`else
        exp_sw = PRE_V;
`endif
        for (int i = 1; i < 32; i++) chk($sformatf("sweep_x%0d", i), {32'd0, tb_rf[i]}, {32'd0, exp_sw});

        // contention: grants must alternate starting from core
        push_core(5'd1, 32'hC000_0001); push_core(5'd2, 32'hC000_0002);
        push_aux(5'd3, 32'hA000_0003);  push_aux(5'd4, 32'hA000_0004);
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0);
            seq = {seq[2:0], e_ar};
        end
        chk("contend_order", {60'd0, seq}, 64'b0101);
        drain();
        chk("cont_x1", {32'd0, tb_rf[1]}, {32'd0, 32'hC000_0001});
        chk("cont_x2", {32'd0, tb_rf[2]}, {32'd0, 32'hC000_0002});
        chk("cont_x3", {32'd0, tb_rf[3]}, {32'd0, 32'hA000_0003});
        chk("cont_x4", {32'd0, tb_rf[4]}, {32'd0, 32'hA000_0004});

        push_core(5'd5, 32'h1234_5678);
        drain();
        chk("core_x5", {32'd0, tb_rf[5]}, {32'd0, 32'h1234_5678});

        push_aux(5'd0, 32'hFFFF_FFFF);
        drain();
        chk("x0_untouched", {63'd0, x0_hit}, 64'd0);

        repeat (200) begin
            if ($urandom_range(99) < 45 && core_q.size() < 2) push_core(5'($urandom_range(31)), $urandom);
            if ($urandom_range(99) < 35 && aux_q.size() < 2)  push_aux(5'($urandom_range(31)), $urandom);
            cycle(1'b0);
        end
        drain();
        chk("x0_after_rand", {63'd0, x0_hit}, 64'd0);

        // reset while a core write is being accepted
        push_core(5'd7, 32'h0707_0707);
        drain();
        push_core(5'd7, 32'h7777_7777);
        cycle(1'b1);
        chk("rst_accept", {63'd0, e_cr}, 64'd1);
        repeat (2) cycle(1'b0);
        #1;
        chk("rst_drop_x7", {32'd0, tb_rf[7]}, {32'd0, 32'h0707_0707});
        wait_init();
        drain();
        for (int i = 1; i < 32; i++) chk($sformatf("final_x%0d", i), {32'd0, tb_rf[i]}, {32'd0, m_rf[i]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
